// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: opcode encoding, request/response bundles and opcode legality.
package alu_share_arbiter_pkg;

    localparam int ALU_OP_W  = 3;
    localparam int kNUM_OPS  = 6;
    localparam int ALU_DEF_W = 8;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_SLL = 3'd3,
        OP_SRL = 3'd4,
        OP_XOR = 3'd5
    } ALUOp_mne;

    typedef struct packed {
        logic [ALU_OP_W-1:0]  op;
        logic [ALU_DEF_W-1:0] a;
        logic [ALU_DEF_W-1:0] b;
    } alu_req_t;

    typedef struct packed {
        logic                 id;
        logic [ALU_DEF_W-1:0] result;
        logic                 carry;
        logic                 zero;
        logic                 err;
    } alu_rsp_t;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        return op < ALU_OP_W'(kNUM_OPS);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two valid/ready request ports and one valid/ready response port around the shared ALU.
interface alu_share_arbiter_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter_alu_core.sv
// Purely combinational ALU: ADD/SUB/AND/SLL/SRL/XOR on unsigned operands, flags illegal opcodes.
module alu_core
    import alu_share_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [W-1:0]        a_i,
    input  logic [W-1:0]        b_i,
    output logic [W-1:0]        result_o,
    output logic                carry_o,
    output logic                err_o
);
    localparam int SHW = $clog2(W);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       shift_oor;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    // W is a power of two, so any set bit at or above SHW means the amount is >= W
    assign shift_oor = |b_i[W-1:SHW];

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        err_o    = ~is_legal_op(op_i);
        case (ALUOp_mne'(op_i))
            OP_ADD: {carry_o, result_o} = sum;
            OP_SUB: {carry_o, result_o} = diff;
            OP_AND: result_o = a_i & b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SLL: result_o = shift_oor ? '0 : (a_i << b_i[SHW-1:0]);
            OP_SRL: result_o = shift_oor ? '0 : (a_i >> b_i[SHW-1:0]);
            default: result_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single registered result slot.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus
);
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [W-1:0]        result_q;
    logic                carry_q;
    logic                zero_q;
    logic                err_q;
    logic                last_grant_q;

    logic                any_valid;
    logic                grant;
    logic                can_accept;
    logic                accept;
    logic [ALU_OP_W-1:0] sel_op;
    logic [W-1:0]        sel_a;
    logic [W-1:0]        sel_b;
    logic [W-1:0]        alu_result;
    logic                alu_carry;
    logic                alu_err;

    assign any_valid  = bus.req0_valid | bus.req1_valid;
    // Contested cycles go to the port that did not win last time
    assign grant      = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign can_accept = ~rsp_valid_q | bus.rsp_ready;
    assign accept     = can_accept & any_valid & ~reset;

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;

    assign sel_op = grant ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

    alu_core #(.W(W)) u_alu (
        .op_i     (sel_op),
        .a_i      (sel_a),
        .b_i      (sel_b),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .err_o    (alu_err)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant;
            result_q     <= alu_result;
            carry_q      <= alu_carry;
            zero_q       <= (alu_result == '0);
            err_q        <= alu_err;
            last_grant_q <= grant;
        end else if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;
endmodule
